// File: rtl/exc_pc_ctrl.sv
// Exception sequencer and PC-source control: forwards normal PC updates from
// main control, and on an exception saves EPC, fetches the handler vector and loads the PC.
module exc_pc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_req,
    input  logic [1:0]  pc_req_sel,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [7:0]  mem_data_in,
    output logic [1:0]  PCSourceCtrl,
    output logic        PCWrite,
    output logic        EPCWrite,
    output logic [31:0] Exception_Destiny,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_read,
    output logic        busy,
    output logic [1:0]  exc_cause
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        LOAD    = 3'd4
    } state_t;

    localparam logic [1:0] SRC_EXC = 2'b00;
    localparam logic [1:0] SRC_EPC = 2'b01;
    localparam logic [1:0] SRC_ALU = 2'b10;
    localparam logic [1:0] SRC_SL2 = 2'b11;

    state_t      state;
    state_t      next_state;
    logic        any_exc;
    logic [1:0]  new_cause;
    logic [31:0] new_addr;
    logic [31:0] vec_addr;
    logic [7:0]  vec_reg;

    assign any_exc = exc_opcode | exc_overflow | exc_div0;

    // Priority encode the exception sources: opcode beats overflow beats div0.
    always_comb begin
        new_cause = 2'b00;
        new_addr  = 32'd0;
        if (exc_opcode) begin
            new_cause = 2'b01;
            new_addr  = 32'd253;
        end else if (exc_overflow) begin
            new_cause = 2'b10;
            new_addr  = 32'd254;
        end else if (exc_div0) begin
            new_cause = 2'b11;
            new_addr  = 32'd255;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = any_exc ? SAVE : IDLE;
            SAVE:    next_state = READ;
            READ:    next_state = CAPTURE;
            CAPTURE: next_state = LOAD;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Cause and vector address are latched only when an exception is accepted,
    // so inputs arriving mid-sequence cannot disturb them.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cause <= 2'b00;
            vec_addr  <= 32'd0;
            vec_reg   <= 8'd0;
        end else begin
            if (state == IDLE && any_exc) begin
                exc_cause <= new_cause;
                vec_addr  <= new_addr;
            end
            if (state == CAPTURE) begin
                vec_reg <= mem_data_in;
            end
        end
    end

    always_comb begin
        PCWrite      = 1'b0;
        PCSourceCtrl = SRC_EXC;
        EPCWrite     = 1'b0;
        exc_mem_read = 1'b0;
        exc_mem_addr = 32'd0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!any_exc && pc_req && pc_req_sel != 2'b11) begin
                    PCWrite = 1'b1;
                    case (pc_req_sel)
                        2'b00:   PCSourceCtrl = SRC_ALU;
                        2'b01:   PCSourceCtrl = SRC_SL2;
                        default: PCSourceCtrl = SRC_EPC;
                    endcase
                end
            end
            SAVE:    EPCWrite = 1'b1;
            READ: begin
                exc_mem_read = 1'b1;
                exc_mem_addr = vec_addr;
            end
            CAPTURE: ;
            LOAD: begin
                PCWrite      = 1'b1;
                PCSourceCtrl = SRC_EXC;
            end
            default: busy = 1'b0;
        endcase
    end

    assign Exception_Destiny = {24'b0, vec_reg};

endmodule

// File: tb/tb_exc_pc_ctrl.sv
// Directed bench for exc_pc_ctrl: one-cycle vectors from a table, then hand-written
// sequences for ignored inputs, exception latency and mid-sequence reset.
module tb_exc_pc_ctrl;

    typedef struct {
        logic        rst;
        logic        req;
        logic [1:0]  sel;
        logic        eop;
        logic        eov;
        logic        ed0;
        logic [7:0]  mem;
        logic        pcw;
        logic [1:0]  src;
        logic        epcw;
        logic        rd;
        logic [31:0] addr;
        logic        bsy;
        logic [1:0]  cause;
        logic [31:0] dest;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        pc_req;
    logic [1:0]  pc_req_sel;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [7:0]  mem_data_in;
    logic [1:0]  PCSourceCtrl;
    logic        PCWrite;
    logic        EPCWrite;
    logic [31:0] Exception_Destiny;
    logic [31:0] exc_mem_addr;
    logic        exc_mem_read;
    logic        busy;
    logic [1:0]  exc_cause;

    int test_count = 0;
    int fail_count = 0;
    vec_t tbl[18];
    vec_t seq[7];

    exc_pc_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .pc_req            (pc_req),
        .pc_req_sel        (pc_req_sel),
        .exc_opcode        (exc_opcode),
        .exc_overflow      (exc_overflow),
        .exc_div0          (exc_div0),
        .mem_data_in       (mem_data_in),
        .PCSourceCtrl      (PCSourceCtrl),
        .PCWrite           (PCWrite),
        .EPCWrite          (EPCWrite),
        .Exception_Destiny (Exception_Destiny),
        .exc_mem_addr      (exc_mem_addr),
        .exc_mem_read      (exc_mem_read),
        .busy              (busy),
        .exc_cause         (exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic req, input logic [1:0] sel,
        input logic eop, input logic eov, input logic ed0, input logic [7:0] mem,
        input logic pcw, input logic [1:0] src, input logic epcw, input logic rd,
        input logic [31:0] addr, input logic bsy, input logic [1:0] cause,
        input logic [31:0] dest);
        vec_t v;
        v.rst = rst;  v.req = req;  v.sel = sel;  v.eop = eop;  v.eov = eov;
        v.ed0 = ed0;  v.mem = mem;  v.pcw = pcw;  v.src = src;  v.epcw = epcw;
        v.rd = rd;    v.addr = addr; v.bsy = bsy; v.cause = cause; v.dest = dest;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] want);
        test_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset        = v.rst;
        pc_req       = v.req;
        pc_req_sel   = v.sel;
        exc_opcode   = v.eop;
        exc_overflow = v.eov;
        exc_div0     = v.ed0;
        mem_data_in  = v.mem;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkField({tag, " PCWrite"},           {31'd0, PCWrite},      {31'd0, v.pcw});
        checkField({tag, " PCSourceCtrl"},      {30'd0, PCSourceCtrl}, {30'd0, v.src});
        checkField({tag, " EPCWrite"},          {31'd0, EPCWrite},     {31'd0, v.epcw});
        checkField({tag, " exc_mem_read"},      {31'd0, exc_mem_read}, {31'd0, v.rd});
        checkField({tag, " busy"},              {31'd0, busy},         {31'd0, v.bsy});
        checkField({tag, " exc_cause"},         {30'd0, exc_cause},    {30'd0, v.cause});
        checkField({tag, " Exception_Destiny"}, Exception_Destiny,     v.dest);
        if (v.rd) checkField({tag, " exc_mem_addr"}, exc_mem_addr, v.addr);
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput(tag, v);
    endtask

    initial begin
        int pcw_cycle;
        int epcw_cycle;
        int rd_cycle;
        int epcw_cnt;
        logic [31:0] dest_at_load;

        applyStimulus(mk(1, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        //              rst req sel    eop eov ed0 mem    pcw src    epw rd addr    bsy cause  dest
        tbl[0]  = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        tbl[1]  = mk(0, 1, 2'b01, 0, 0, 0, 8'h00, 1, 2'b11, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        tbl[2]  = mk(0, 1, 2'b00, 0, 0, 0, 8'h00, 1, 2'b10, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        tbl[3]  = mk(0, 1, 2'b10, 0, 0, 0, 8'h00, 1, 2'b01, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        tbl[4]  = mk(0, 1, 2'b11, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        tbl[5]  = mk(0, 0, 2'b01, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        tbl[6]  = mk(0, 0, 2'b00, 0, 1, 0, 8'hAA, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        tbl[7]  = mk(0, 0, 2'b00, 0, 0, 0, 8'hAA, 0, 2'b00, 1, 0, 32'd0,   1, 2'b10, 32'h00);
        tbl[8]  = mk(0, 0, 2'b00, 0, 0, 0, 8'hAA, 0, 2'b00, 0, 1, 32'd254, 1, 2'b10, 32'h00);
        tbl[9]  = mk(0, 0, 2'b00, 0, 0, 0, 8'h3C, 0, 2'b00, 0, 0, 32'd0,   1, 2'b10, 32'h00);
        tbl[10] = mk(0, 0, 2'b00, 0, 0, 0, 8'h55, 1, 2'b00, 0, 0, 32'd0,   1, 2'b10, 32'h3C);
        tbl[11] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b10, 32'h3C);
        tbl[12] = mk(0, 1, 2'b00, 1, 0, 1, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b10, 32'h3C);
        tbl[13] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 32'd0,   1, 2'b01, 32'h3C);
        tbl[14] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 0, 1, 32'd253, 1, 2'b01, 32'h3C);
        tbl[15] = mk(0, 0, 2'b00, 0, 0, 0, 8'h7F, 0, 2'b00, 0, 0, 32'd0,   1, 2'b01, 32'h3C);
        tbl[16] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 1, 2'b00, 0, 0, 32'd0,   1, 2'b01, 32'h7F);
        tbl[17] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b01, 32'h7F);

        for (int i = 0; i < 18; i++) begin
            step($sformatf("row%0d", i), tbl[i]);
            if (i == 0) checkField("reset exc_mem_addr", exc_mem_addr, 32'd0);
        end

        // div0 sequence with a second exception and a pc_req arriving while busy
        seq[0] = mk(0, 0, 2'b00, 0, 0, 1, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b01, 32'h7F);
        seq[1] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 32'd0,   1, 2'b11, 32'h7F);
        seq[2] = mk(0, 0, 2'b00, 1, 0, 0, 8'h00, 0, 2'b00, 0, 1, 32'd255, 1, 2'b11, 32'h7F);
        seq[3] = mk(0, 1, 2'b00, 0, 0, 0, 8'h12, 0, 2'b00, 0, 0, 32'd0,   1, 2'b11, 32'h7F);
        seq[4] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 1, 2'b00, 0, 0, 32'd0,   1, 2'b11, 32'h12);
        seq[5] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b11, 32'h12);
        seq[6] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b11, 32'h12);
        for (int i = 0; i < 7; i++) step($sformatf("busy%0d", i), seq[i]);

        // Latency of an overflow exception, watched with a bounded cycle budget
        @(negedge clk);
        applyStimulus(mk(0, 0, 2'b00, 0, 1, 0, 8'h99, 0, 0, 0, 0, 0, 0, 0, 0));
        pcw_cycle = -1; epcw_cycle = -1; rd_cycle = -1; epcw_cnt = 0; dest_at_load = 32'd0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            applyStimulus(mk(0, 0, 2'b00, 0, 0, 0, 8'h99, 0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            if (EPCWrite) begin
                epcw_cnt++;
                if (epcw_cycle < 0) epcw_cycle = cyc;
            end
            if (exc_mem_read && rd_cycle < 0) rd_cycle = cyc;
            if (PCWrite) begin
                pcw_cycle = cyc;
                dest_at_load = Exception_Destiny;
                break;
            end
        end
        checkField("lat PCWrite within budget", {31'd0, pcw_cycle > 0}, 32'd1);
        checkField("lat PCWrite cycle",  pcw_cycle,  32'd4);
        checkField("lat EPCWrite cycle", epcw_cycle, 32'd1);
        checkField("lat EPCWrite count", epcw_cnt,   32'd1);
        checkField("lat read cycle",     rd_cycle,   32'd2);
        checkField("lat destiny",        dest_at_load, 32'h99);
        checkField("lat cause",          {30'd0, exc_cause}, 32'd2);

        // Reset during READ aborts, then reset beats a simultaneous exception
        seq[0] = mk(0, 0, 2'b00, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b10, 32'h99);
        seq[1] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 32'd0,   1, 2'b01, 32'h99);
        seq[2] = mk(1, 0, 2'b00, 0, 0, 0, 8'h44, 0, 2'b00, 0, 1, 32'd253, 1, 2'b01, 32'h99);
        seq[3] = mk(0, 0, 2'b00, 0, 0, 0, 8'h44, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        seq[4] = mk(0, 0, 2'b00, 0, 0, 0, 8'h44, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        seq[5] = mk(1, 1, 2'b01, 0, 1, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        seq[6] = mk(0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 32'd0,   0, 2'b00, 32'h00);
        for (int i = 0; i < 7; i++) step($sformatf("rst%0d", i), seq[i]);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
